// File: rtl/cpu_run_pkg.sv
// Shared types and defaults for the CPU run-control monitor.
package cpu_run_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } run_state_e;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_SYSCALL = 2'd1;
    localparam logic [1:0] CAUSE_HALT    = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    localparam logic [31:0] SYSCALL_OPC_DEFAULT = 32'h0000000C;
    localparam logic [31:0] EXIT_CODE_DEFAULT   = 32'd10;

endpackage

// File: rtl/cpu_run_monitor_trace_ring.sv
// Circular trace of retired (pc, insn) pairs with a saturating fill count
// and a registered read indexed backwards from the newest entry.
module trace_ring #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int INSN_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_pc,
    input  logic [INSN_W-1:0]        wr_insn,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [$clog2(DEPTH):0]   count,
    output logic [ADDR_W-1:0]        rd_pc,
    output logic [INSN_W-1:0]        rd_insn
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [ADDR_W-1:0] pc_mem_d   [DEPTH];
    logic [INSN_W-1:0] insn_mem_q [DEPTH];
    logic [INSN_W-1:0] insn_mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] rd_pc_q, rd_pc_d;
    logic [INSN_W-1:0] rd_insn_q, rd_insn_d;

    always_comb begin
        pc_mem_d   = pc_mem_q;
        insn_mem_d = insn_mem_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (wr_en) begin
            pc_mem_d[wr_ptr_q]   = wr_pc;
            insn_mem_d[wr_ptr_q] = wr_insn;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            if (count_q != CNT_W'(DEPTH)) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // Reads see the pre-write state, so a same-cycle write is not forwarded.
    always_comb begin
        rd_ptr    = wr_ptr_q - PTR_W'(1) - rd_idx;
        rd_pc_d   = '0;
        rd_insn_d = '0;
        if ({1'b0, rd_idx} < count_q) begin
            rd_pc_d   = pc_mem_q[rd_ptr];
            rd_insn_d = insn_mem_q[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                insn_mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            count_q   <= '0;
            rd_pc_q   <= '0;
            rd_insn_q <= '0;
        end else begin
            pc_mem_q   <= pc_mem_d;
            insn_mem_q <= insn_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            rd_pc_q    <= rd_pc_d;
            rd_insn_q  <= rd_insn_d;
        end
    end

    assign count   = count_q;
    assign rd_pc   = rd_pc_q;
    assign rd_insn = rd_insn_q;

endmodule

// File: rtl/cpu_run_monitor.sv
// Run-control monitor: detects program termination (exit syscall, PC self-loop
// halt, cycle timeout), counts cycles/retirements and keeps a retirement trace.
module cpu_run_monitor
    import cpu_run_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                INSN_W         = 32,
    parameter int                TRACE_DEPTH    = 8,
    parameter int                HALT_CYCLES    = 4,
    parameter int                TIMEOUT_CYCLES = 4096,
    parameter logic [INSN_W-1:0] SYSCALL_OPC    = INSN_W'(SYSCALL_OPC_DEFAULT),
    parameter logic [31:0]       EXIT_CODE      = EXIT_CODE_DEFAULT,
    parameter int                CNT_W          = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ADDR_W-1:0]              pc,
    input  logic [INSN_W-1:0]              insn,
    input  logic                           insn_valid,
    input  logic [31:0]                    v0,
    output logic                           running,
    output logic                           done,
    output logic [1:0]                     exit_cause,
    output logic [CNT_W-1:0]               cycle_count,
    output logic [CNT_W-1:0]               retired_count,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
    output logic [ADDR_W-1:0]              trace_pc,
    output logic [INSN_W-1:0]              trace_insn
);

    localparam int                HALT_W       = $clog2(HALT_CYCLES + 1);
    localparam logic [HALT_W-1:0] HALT_LIMIT   = HALT_W'(HALT_CYCLES);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    run_state_e        state_q, state_d;
    logic [1:0]        cause_q, cause_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [HALT_W-1:0] halt_len_q, halt_len_d;
    logic [ADDR_W-1:0] last_pc_q, last_pc_d;
    logic              run_start;
    logic              retire;
    logic              syscall_hit;
    logic              halt_hit;
    logic              timeout_hit;

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        cycle_d     = cycle_q;
        retired_d   = retired_q;
        halt_len_d  = halt_len_q;
        last_pc_d   = last_pc_q;
        run_start   = 1'b0;
        retire      = 1'b0;
        syscall_hit = 1'b0;
        halt_hit    = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RUN;
                    cause_d    = CAUSE_NONE;
                    cycle_d    = '0;
                    retired_d  = '0;
                    halt_len_d = '0;
                    last_pc_d  = '0;
                    run_start  = 1'b1;
                end
            end
            RUN: begin
                retire      = insn_valid;
                timeout_hit = (cycle_q == TIMEOUT_LAST);
                if (!(&cycle_q)) begin
                    cycle_d = cycle_q + CNT_W'(1);
                end
                if (insn_valid) begin
                    if (!(&retired_q)) begin
                        retired_d = retired_q + CNT_W'(1);
                    end
                    // A cleared last_pc with halt_len 0 still yields 1 on the first retirement.
                    if (pc == last_pc_q) begin
                        if (halt_len_q != HALT_LIMIT) begin
                            halt_len_d = halt_len_q + HALT_W'(1);
                        end
                    end else begin
                        halt_len_d = HALT_W'(1);
                    end
                    last_pc_d   = pc;
                    syscall_hit = (insn == SYSCALL_OPC) && (v0 == EXIT_CODE);
                    halt_hit    = (halt_len_d == HALT_LIMIT);
                end
                if (syscall_hit) begin
                    state_d = DONE;
                    cause_d = CAUSE_SYSCALL;
                end else if (halt_hit) begin
                    state_d = DONE;
                    cause_d = CAUSE_HALT;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cause_q    <= CAUSE_NONE;
            cycle_q    <= '0;
            retired_q  <= '0;
            halt_len_q <= '0;
            last_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            cycle_q    <= cycle_d;
            retired_q  <= retired_d;
            halt_len_q <= halt_len_d;
            last_pc_q  <= last_pc_d;
        end
    end

    trace_ring #(
        .DEPTH  (TRACE_DEPTH),
        .ADDR_W (ADDR_W),
        .INSN_W (INSN_W)
    ) u_trace (
        .clk     (clk),
        .rst_n   (reset),
        .clear   (run_start),
        .wr_en   (retire),
        .wr_pc   (pc),
        .wr_insn (insn),
        .rd_idx  (trace_rd_idx),
        .count   (trace_count),
        .rd_pc   (trace_pc),
        .rd_insn (trace_insn)
    );

    assign running       = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign exit_cause    = cause_q;
    assign cycle_count   = cycle_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: a per-cycle vector table plus
// hand-written sequences for timeout, halt, trace wrap, priority and reset.
module tb_cpu_run_monitor;

    localparam logic [31:0] SYS = 32'h0000000C;
    localparam logic [31:0] A1  = 32'h24000001;
    localparam logic [31:0] A2  = 32'h24000002;
    localparam logic [31:0] A3  = 32'h24000003;
    localparam logic [31:0] A5  = 32'h24000005;
    localparam logic [31:0] A6  = 32'h24000006;
    localparam logic [31:0] A7  = 32'h24000007;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        insn_valid;
    logic [31:0] v0;
    logic        running;
    logic        done;
    logic [1:0]  exit_cause;
    logic [31:0] cycle_count;
    logic [31:0] retired_count;
    logic [3:0]  trace_count;
    logic [2:0]  trace_rd_idx;
    logic [31:0] trace_pc;
    logic [31:0] trace_insn;

    int tests_run;
    int tests_failed;

    cpu_run_monitor #(
        .ADDR_W         (32),
        .INSN_W         (32),
        .TRACE_DEPTH    (8),
        .HALT_CYCLES    (4),
        .TIMEOUT_CYCLES (16),
        .SYSCALL_OPC    (SYS),
        .EXIT_CODE      (32'd10),
        .CNT_W          (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .pc            (pc),
        .insn          (insn),
        .insn_valid    (insn_valid),
        .v0            (v0),
        .running       (running),
        .done          (done),
        .exit_cause    (exit_cause),
        .cycle_count   (cycle_count),
        .retired_count (retired_count),
        .trace_count   (trace_count),
        .trace_rd_idx  (trace_rd_idx),
        .trace_pc      (trace_pc),
        .trace_insn    (trace_insn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] v0;
        logic [2:0]  idx;
        logic        exp_run;
        logic        exp_done;
        logic [1:0]  exp_cause;
        logic [31:0] exp_cycle;
        logic [31:0] exp_ret;
        logic [3:0]  exp_tc;
        logic [31:0] exp_tpc;
        logic [31:0] exp_tinsn;
    } vec_t;

    vec_t vecs [13];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it, and settle 1ns past the edge.
    task automatic applyStimulus(input logic s, input logic vld, input logic [31:0] p,
                                 input logic [31:0] i, input logic [31:0] v, input logic [2:0] idx);
        start        = s;
        insn_valid   = vld;
        pc           = p;
        insn         = i;
        v0           = v;
        trace_rd_idx = idx;
        @(posedge clk);
        #1;
    endtask

    task automatic checkState(input string tag, input logic r, input logic d, input logic [1:0] c,
                              input logic [31:0] cyc, input logic [31:0] ret, input logic [3:0] tc);
        checkOutput({tag, " running"}, running, r);
        checkOutput({tag, " done"}, done, d);
        checkOutput({tag, " exit_cause"}, exit_cause, c);
        checkOutput({tag, " cycle_count"}, cycle_count, cyc);
        checkOutput({tag, " retired_count"}, retired_count, ret);
        checkOutput({tag, " trace_count"}, trace_count, tc);
    endtask

    task automatic bubbles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // start,valid,pc,insn,v0,idx | running,done,cause,cycle,retired,tcount,tpc,tinsn
        vecs[0]  = '{1'b1, 1'b0, 32'h000, 32'h0, 32'd0,  3'd0, 1'b1, 1'b0, 2'd0, 32'd0,  32'd0, 4'd0, 32'h000, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h100, A1,    32'd0,  3'd0, 1'b1, 1'b0, 2'd0, 32'd1,  32'd1, 4'd1, 32'h000, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 32'h104, A2,    32'd0,  3'd0, 1'b1, 1'b0, 2'd0, 32'd2,  32'd2, 4'd2, 32'h100, A1};
        vecs[3]  = '{1'b0, 1'b1, 32'h108, A3,    32'd0,  3'd0, 1'b1, 1'b0, 2'd0, 32'd3,  32'd3, 4'd3, 32'h104, A2};
        vecs[4]  = '{1'b0, 1'b1, 32'h10C, SYS,   32'd4,  3'd0, 1'b1, 1'b0, 2'd0, 32'd4,  32'd4, 4'd4, 32'h108, A3};
        vecs[5]  = '{1'b1, 1'b1, 32'h110, A5,    32'd4,  3'd0, 1'b1, 1'b0, 2'd0, 32'd5,  32'd5, 4'd5, 32'h10C, SYS};
        vecs[6]  = '{1'b0, 1'b0, 32'h000, 32'h0, 32'd4,  3'd1, 1'b1, 1'b0, 2'd0, 32'd6,  32'd5, 4'd5, 32'h10C, SYS};
        vecs[7]  = '{1'b0, 1'b0, 32'h000, 32'h0, 32'd4,  3'd5, 1'b1, 1'b0, 2'd0, 32'd7,  32'd5, 4'd5, 32'h000, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 32'h114, A6,    32'd4,  3'd0, 1'b1, 1'b0, 2'd0, 32'd8,  32'd6, 4'd6, 32'h110, A5};
        vecs[9]  = '{1'b0, 1'b1, 32'h118, A7,    32'd4,  3'd0, 1'b1, 1'b0, 2'd0, 32'd9,  32'd7, 4'd7, 32'h114, A6};
        vecs[10] = '{1'b0, 1'b1, 32'h11C, SYS,   32'd10, 3'd0, 1'b0, 1'b1, 2'd1, 32'd10, 32'd8, 4'd8, 32'h118, A7};
        vecs[11] = '{1'b0, 1'b0, 32'h000, 32'h0, 32'd10, 3'd0, 1'b0, 1'b1, 2'd1, 32'd10, 32'd8, 4'd8, 32'h11C, SYS};
        vecs[12] = '{1'b0, 1'b0, 32'h000, 32'h0, 32'd10, 3'd7, 1'b0, 1'b1, 2'd1, 32'd10, 32'd8, 4'd8, 32'h100, A1};

        reset        = 1'b0;
        start        = 1'b0;
        insn_valid   = 1'b0;
        pc           = '0;
        insn         = '0;
        v0           = '0;
        trace_rd_idx = '0;
        repeat (2) @(posedge clk);
        #1;
        checkState("reset", 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
        checkOutput("reset trace_pc", trace_pc, 32'h0);
        checkOutput("reset trace_insn", trace_insn, 32'h0);
        reset = 1'b1;

        // Syscall exit run with an ordinary v0=4 syscall and an ignored start.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].start, vecs[i].valid, vecs[i].pc, vecs[i].insn, vecs[i].v0, vecs[i].idx);
            checkState($sformatf("vec%0d", i), vecs[i].exp_run, vecs[i].exp_done, vecs[i].exp_cause,
                       vecs[i].exp_cycle, vecs[i].exp_ret, vecs[i].exp_tc);
            checkOutput($sformatf("vec%0d trace_pc", i), trace_pc, vecs[i].exp_tpc);
            checkOutput($sformatf("vec%0d trace_insn", i), trace_insn, vecs[i].exp_tinsn);
        end

        // Timeout, restarting from DONE with no retirements.
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0);
        checkState("to start", 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
        bubbles(15);
        checkState("to cyc15", 1'b1, 1'b0, 2'd0, 32'd15, 32'd0, 4'd0);
        bubbles(1);
        checkState("to end", 1'b0, 1'b1, 2'd3, 32'd16, 32'd0, 4'd0);
        checkOutput("to trace_pc", trace_pc, 32'h0);

        // Halt: a different PC resets the run length; final four have bubbles.
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 3'd0);
        checkState("halt pre", 1'b1, 1'b0, 2'd0, 32'd3, 32'd3, 4'd3);
        applyStimulus(1'b0, 1'b1, 32'h44, 32'h0, 32'h0, 3'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 3'd0);
            bubbles(1);
        end
        checkState("halt 3rd", 1'b1, 1'b0, 2'd0, 32'd10, 32'd7, 4'd7);
        applyStimulus(1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 3'd0);
        checkState("halt end", 1'b0, 1'b1, 2'd2, 32'd11, 32'd8, 4'd8);

        // Trace wrap: 11 retirements into 8 entries, then read newest and oldest.
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0);
        for (int k = 0; k < 11; k++) applyStimulus(1'b0, 1'b1, 32'(4 * k), 32'h1000 + 32'(k), 32'h0, 3'd0);
        checkState("wrap fill", 1'b1, 1'b0, 2'd0, 32'd11, 32'd11, 4'd8);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0);
        checkOutput("wrap idx0 pc", trace_pc, 32'h28);
        checkOutput("wrap idx0 insn", trace_insn, 32'h100A);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd7);
        checkOutput("wrap idx7 pc", trace_pc, 32'h0C);
        checkOutput("wrap idx7 insn", trace_insn, 32'h1003);
        bubbles(3);
        checkState("wrap timeout", 1'b0, 1'b1, 2'd3, 32'd16, 32'd11, 4'd8);

        // Syscall, halt and timeout all on the 16th RUN cycle.
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0);
        bubbles(12);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 32'h80, SYS, 32'd4, 3'd0);
        checkState("prio1 pre", 1'b1, 1'b0, 2'd0, 32'd15, 32'd3, 4'd3);
        applyStimulus(1'b0, 1'b1, 32'h80, SYS, 32'd10, 3'd0);
        checkState("prio1 end", 1'b0, 1'b1, 2'd1, 32'd16, 32'd4, 4'd4);

        // Halt and timeout together without a syscall.
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0);
        bubbles(12);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 32'h80, 32'h0, 32'd10, 3'd0);
        checkState("prio2 end", 1'b0, 1'b1, 2'd2, 32'd16, 32'd4, 4'd4);

        // Asynchronous reset between edges, then a clean restart.
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0);
        applyStimulus(1'b0, 1'b1, 32'h200, A1, 32'h0, 3'd0);
        applyStimulus(1'b0, 1'b1, 32'h204, A2, 32'h0, 3'd0);
        checkOutput("pre-reset trace_pc", trace_pc, 32'h200);
        insn_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        checkState("async reset", 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
        checkOutput("async reset trace_pc", trace_pc, 32'h0);
        checkOutput("async reset trace_insn", trace_insn, 32'h0);
        #2;
        reset = 1'b1;
        bubbles(1);
        checkState("post release", 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0);
        checkState("restart", 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
        applyStimulus(1'b0, 1'b1, 32'h300, A3, 32'h0, 3'd0);
        checkState("restart ret", 1'b1, 1'b0, 2'd0, 32'd1, 32'd1, 4'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0);
        checkOutput("restart trace_pc", trace_pc, 32'h300);
        checkOutput("restart trace_insn", trace_insn, A3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

Run-control and trace monitor that sits beside a CPU core in simulation and FPGA bring-up builds. It replaces fixed-delay end-of-run handling with hardware termination detection: an exit syscall, a self-loop halt, or a cycle timeout. While a program runs it counts cycles and retired instructions and keeps a circular trace of the last retired (PC, instruction) pairs. Benches and debug logic read that trace after the run ends.

## Interface
Parameters:
- ADDR_W, 32, PC width
- INSN_W, 32, instruction width
- TRACE_DEPTH, 8, trace entries; power of two, ≥2
- HALT_CYCLES, 4, consecutive retirements at an unchanged PC that declare a halt (≥2)
- TIMEOUT_CYCLES, 4096, RUN cycles before a timeout
- SYSCALL_OPC, 32'h0000000C, instruction encoding of a syscall
- EXIT_CODE, 10, v0 value that marks a syscall as exit
- CNT_W, 32, width of the cycle and retire counters

Ports:
- clk, in, 1, clock; all state updates on the rising edge
- reset, in, 1, asynchronous, active-low reset; 0 forces reset state immediately
- start, in, 1, single-cycle request to begin a run
- pc, in, ADDR_W, PC of the instruction retiring this cycle
- insn, in, INSN_W, instruction retiring this cycle
- insn_valid, in, 1, pc/insn are a retirement this cycle
- v0, in, 32, current value of register $v0
- running, out, 1, FSM is in RUN
- done, out, 1, FSM is in DONE
- exit_cause, out, 2, 0 none, 1 syscall exit, 2 PC halt, 3 timeout
- cycle_count, out, CNT_W, RUN cycles elapsed
- retired_count, out, CNT_W, retirements counted
- trace_count, out, $clog2(TRACE_DEPTH)+1, valid trace entries
- trace_rd_idx, in, $clog2(TRACE_DEPTH), 0 = most recent entry
- trace_pc, out, ADDR_W, registered trace read data
- trace_insn, out, INSN_W, registered trace read data

## Operation
- Reset values: FSM in IDLE; running=0; done=0; exit_cause=0; all counters 0; trace_count=0; write pointer 0; trace_pc=0; trace_insn=0; halt run length 0.
- IDLE → RUN when start=1. The entry edge clears the counters, trace_count, write pointer, halt run length and exit_cause.
- RUN, every cycle: cycle_count += 1. When insn_valid=1:
  - retired_count += 1.
  - (pc, insn) is written at the write pointer.
  - The write pointer increments modulo TRACE_DEPTH.
  - trace_count increments, saturating at TRACE_DEPTH.
- Halt run length, in RUN with insn_valid=1:
  - If pc equals the previous retired pc, the run length increments.
  - Otherwise it resets to 1.
  - Cycles with insn_valid=0 leave it unchanged.
- Termination conditions, each evaluated on the current RUN cycle:
  - Syscall exit: insn_valid=1, insn==SYSCALL_OPC and v0==EXIT_CODE.
  - PC halt: the halt run length reaches HALT_CYCLES, counting this cycle's retirement.
  - Timeout: cycle_count==TIMEOUT_CYCLES-1, i.e. the TIMEOUT_CYCLES-th RUN cycle.
- Any termination: on the next edge the FSM enters DONE and exit_cause latches the cause.
  - Priority when several hold at once: syscall > halt > timeout.
  - The terminating cycle's counts and trace write still take effect.
- DONE holds all counters and trace state until start=1, which restarts exactly like IDLE → RUN.
- start while in RUN is ignored.
- A syscall whose v0≠EXIT_CODE is an ordinary retirement.
- Both counters saturate at all-ones; they never wrap.
- Trace read: at the edge, trace_pc/trace_insn ← entry (wr_ptr−1−trace_rd_idx) mod TRACE_DEPTH. The read is valid in every state.
  - If trace_rd_idx ≥ trace_count, the outputs are 0.

## Timing
- start seen at edge N → running=1 after edge N; cycle N+1 is the first RUN cycle.
- Terminating cycle sampled at edge M → done=1, running=0 and exit_cause valid after edge M.
- Trace read latency: one cycle from trace_rd_idx to trace_pc/trace_insn.
- A write and a read in the same cycle: the read returns the pre-write contents.
- Reset asserted mid-run returns to the reset state asynchronously, with no clock needed. Deassertion is synchronous in effect: the first state change is at the first edge after release.

## Structure
- A shared package `cpu_run_pkg` holds:
  - state enum: IDLE, RUN, DONE
  - exit_cause encodings: CAUSE_NONE, CAUSE_SYSCALL, CAUSE_HALT, CAUSE_TIMEOUT
  - SYSCALL_OPC and EXIT_CODE defaults
- One sub-module, `trace_ring`: a parametrised circular buffer with write pointer, saturating count and registered indexed read. cpu_run_monitor holds the FSM, counters, halt detector and cause priority.

## Test plan
- Syscall exit: start, retire 5 distinct PCs then 0x0000000C with v0=10 → done, exit_cause=1, retired_count=6, trace index 0 = (last pc, 0x0000000C).
- Syscall with v0=4, then 3 more retirements → run continues; retired_count increments past the syscall; no termination.
- Halt: retire PC 0x40 on 4 consecutive valid cycles with idle bubbles between them (HALT_CYCLES=4) → exit_cause=2 after the 4th retirement.
- Timeout: TIMEOUT_CYCLES=16, insn_valid=0 throughout → done after 16 RUN cycles, cycle_count=16, retired_count=0, exit_cause=3.
- Trace wrap: 11 retirements at PCs 0..10 (words) with TRACE_DEPTH=8 → trace_count=8; idx0 = PC 10, idx7 = PC 3; idx≥8 unreachable and idx beyond count returns 0 on an earlier partial run.
- Simultaneous and reset:
  - Syscall exit on the same cycle as the halt and timeout conditions → exit_cause=1.
  - reset pulled low mid-RUN between edges → all outputs are 0 immediately.
  - After release, start restarts a clean run.
